// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
// The early-out path for trivial operands is enabled by DIV_EARLY_OUT_EN.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DW = 16;
  localparam int VW = 8;
  localparam int CW = 5;

  localparam logic [63:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/seq_divider_16x8_if.sv
// Operand/result handshake bundle for the sequential divider.
// master drives operands and accepts results; slave is the divider.
interface seq_divider_16x8_if #(
  parameter int DW = div_pkg::DW,
  parameter int VW = div_pkg::VW
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output in_valid,
    output dividend,
    output divisor,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  in_valid,
    input  dividend,
    input  divisor,
    input  out_ready,
    output in_ready,
    output out_valid,
    output quotient,
    output remainder,
    output div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract.
// The partial remainder carries one spare bit so the shifted MSB never overflows.
module div_step #(
  parameter int VW = div_pkg::VW
) (
  input  logic [VW:0]   pr_i,
  input  logic          bit_i,
  input  logic [VW-1:0] dvs_i,
  output logic [VW:0]   pr_o,
  output logic          q_o
);

  logic [VW:0] shifted;
  logic [VW:0] dvs_ext;

  // shift, compare and conditionally subtract
  always_comb begin
    shifted = {pr_i[VW-1:0], bit_i};
    dvs_ext = {1'b0, dvs_i};
    q_o     = (shifted >= dvs_ext);
    pr_o    = q_o ? (shifted - dvs_ext) : shifted;
  end

endmodule

// File: rtl/seq_divider_16x8.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// Define DIV_EARLY_OUT_EN to finish trivial operands in a single cycle.
module seq_divider_16x8 #(
  parameter int DW = div_pkg::DW,
  parameter int VW = div_pkg::VW,
  parameter int CW = div_pkg::CW
) (
  input  logic                clk,
  input  logic                rst,
  seq_divider_16x8_if.slave   bus
);

  import div_pkg::*;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] dq_q, dq_d;
  logic [VW:0]   pr_q, pr_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic          dbz_q, dbz_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          zflag_q, zflag_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;

  logic          accept;
  logic          div_zero;
  logic          early;
  logic [VW:0]   step_pr;
  logic          step_q;

  assign accept   = (state_q == IDLE) && in_ready_q && bus.in_valid;
  assign div_zero = (bus.divisor == '0);

`ifdef DIV_EARLY_OUT_EN
  assign early = (bus.dividend < DW'(bus.divisor)) ||
                 (bus.dividend == '0);
`else
  assign early = 1'b0;
`endif

  div_step #(.VW(VW)) u_step (
    .pr_i  (pr_q),
    .bit_i (dq_q[DW-1]),
    .dvs_i (dvs_q),
    .pr_o  (step_pr),
    .q_o   (step_q)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state selection
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (div_zero || early) state_d = DONE;
          else                   state_d = BUSY;
        end
      end
      BUSY: begin
        if (count_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // datapath and registered output updates
  always_comb begin
    count_d     = count_q;
    dq_d        = dq_q;
    pr_d        = pr_q;
    dvs_d       = dvs_q;
    dbz_d       = dbz_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    zflag_d     = zflag_q;
    out_valid_d = 1'b0;
    in_ready_d  = (state_d == IDLE);
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          dvs_d   = bus.divisor;
          count_d = CW'(DW);
          if (div_zero) begin
            dq_d  = DW'(DIV_ZERO_QUOT);
            pr_d  = {1'b0, bus.dividend[VW-1:0]};
            dbz_d = 1'b1;
          end else if (early) begin
            dq_d  = '0;
            pr_d  = {1'b0, bus.dividend[VW-1:0]};
            dbz_d = 1'b0;
          end else begin
            dq_d  = bus.dividend;
            pr_d  = '0;
            dbz_d = 1'b0;
          end
        end
      end
      BUSY: begin
        pr_d    = step_pr;
        dq_d    = {dq_q[DW-2:0], step_q};
        count_d = count_q - CW'(1);
      end
      DONE: begin
        if (!out_valid_q) begin
          quot_d      = dq_q;
          rem_d       = pr_q[VW-1:0];
          zflag_d     = dbz_q;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = !bus.out_ready;
        end
      end
      default: ;
    endcase
  end

  // working and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      dq_q        <= '0;
      pr_q        <= '0;
      dvs_q       <= '0;
      dbz_q       <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      zflag_q     <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      count_q     <= count_d;
      dq_q        <= dq_d;
      pr_q        <= pr_d;
      dvs_q       <= dvs_d;
      dbz_q       <= dbz_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      zflag_q     <= zflag_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = zflag_q;

endmodule

// File: tb/tb_seq_divider_16x8.sv
// Directed and randomized checks for seq_divider_16x8.
// Honours DIV_EARLY_OUT_EN for the expected trivial-case latency.
module tb_seq_divider_16x8;

  logic clk;
  logic rst;

  seq_divider_16x8_if #(.DW(16), .VW(8)) bus ();

  seq_divider_16x8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk;
  int n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Issue one operation from a negedge; returns at a negedge after handshake.
  task automatic do_op(input  logic [15:0] dd,
                       input  logic [7:0]  dv,
                       input  int          stall,
                       output logic [15:0] q,
                       output logic [7:0]  r,
                       output logic        z,
                       output int          lat);
    int k;
    k = 0;
    while (!bus.in_ready && k < 64) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_before_op", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.dividend = dd;
    bus.divisor  = dv;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    q = bus.quotient;
    r = bus.remainder;
    z = bus.div_by_zero;
    repeat (stall) @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  logic [15:0] q;
  logic [7:0]  r;
  logic        z;
  int          lat;
  int          seen;
  int          early_lat;

  initial begin
    n_chk         = 0;
    n_pass        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
`ifdef DIV_EARLY_OUT_EN
    early_lat = 1;
`else
    early_lat = 17;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_quot",      {16'd0, bus.quotient},  32'd0);
    check("rst_rem",       {24'd0, bus.remainder}, 32'd0);
    check("rst_dbz",       {31'd0, bus.div_by_zero}, 32'd0);

    // abort an operation mid-flight with a 3-cycle reset
    bus.in_valid = 1'b1;
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd7;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("busy_in_ready", {31'd0, bus.in_ready}, 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("abort_quot",      {16'd0, bus.quotient},  32'd0);
    check("abort_rem",       {24'd0, bus.remainder}, 32'd0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("abort_no_result", seen, 0);

    do_op(16'd1000, 8'd7, 0, q, r, z, lat);
    check("d1000_q",   {16'd0, q}, 32'd142);
    check("d1000_r",   {24'd0, r}, 32'd6);
    check("d1000_z",   {31'd0, z}, 32'd0);
    check("d1000_lat", lat, 17);

    do_op(16'hFFFF, 8'hFF, 0, q, r, z, lat);
    check("ffff_ff_q", {16'd0, q}, 32'h0101);
    check("ffff_ff_r", {24'd0, r}, 32'd0);

    do_op(16'hFFFF, 8'd1, 0, q, r, z, lat);
    check("ffff_1_q", {16'd0, q}, 32'hFFFF);
    check("ffff_1_r", {24'd0, r}, 32'd0);

    do_op(16'h1234, 8'd0, 0, q, r, z, lat);
    check("dz_q",   {16'd0, q}, 32'hFFFF);
    check("dz_r",   {24'd0, r}, 32'h34);
    check("dz_z",   {31'd0, z}, 32'd1);
    check("dz_lat", lat, 1);

    do_op(16'd5, 8'd9, 0, q, r, z, lat);
    check("eo_q",   {16'd0, q}, 32'd0);
    check("eo_r",   {24'd0, r}, 32'd5);
    check("eo_z",   {31'd0, z}, 32'd0);
    check("eo_lat", lat, early_lat);

    do_op(16'd0, 8'd5, 0, q, r, z, lat);
    check("zero_dd_q", {16'd0, q}, 32'd0);
    check("zero_dd_r", {24'd0, r}, 32'd0);
    check("zero_dd_lat", lat, early_lat);

    // backpressure: hold result, drop a stray in_valid pulse
    bus.in_valid = 1'b1;
    bus.dividend = 16'd300;
    bus.divisor  = 8'd13;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("bp_lat", lat, 17);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        bus.in_valid = 1'b1;
        bus.dividend = 16'd99;
        bus.divisor  = 8'd3;
      end else begin
        bus.in_valid = 1'b0;
      end
      check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_quot",  {16'd0, bus.quotient},  32'd23);
      check("bp_rem",   {24'd0, bus.remainder}, 32'd1);
      check("bp_ready", {31'd0, bus.in_ready},  32'd0);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_ready_back", {31'd0, bus.in_ready},  32'd1);
    check("bp_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("bp_pulse_dropped", seen, 0);

    // randomized operations with random output stalls
    for (int n = 0; n < 1500; n++) begin
      logic [15:0] dd;
      logic [7:0]  dv;
      dd = 16'($urandom);
      dv = 8'($urandom);
      if (n % 16 == 0) dv = 8'd0;
      if (n % 8 == 1)  dd = 16'($urandom_range(0, 300));
      do_op(dd, dv, $urandom_range(0, 3), q, r, z, lat);
      check("rand_lat_bound", {31'd0, lat < 64}, 32'd1);
      if (dv == 8'd0) begin
        check("rand_dz", {15'd0, z, q, r}, {15'd0, 1'b1, 16'hFFFF, dd[7:0]});
      end else begin
        check("rand_qr",  32'(q) * 32'(dv) + 32'(r), {16'd0, dd});
        check("rand_rlt", {31'd0, r < dv}, 32'd1);
        check("rand_z",   {31'd0, z}, 32'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
